// File: rtl/bk_multiword_add_seq.sv
// Sequencer that feeds an external WORD_W-bit adder one word per clock, LSW first, to build a wide add.
// Optional signed-overflow output out_ovf is present when BK_SEQ_OVF_EN is defined.
module bk_multiword_add_seq #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_sum,
    output logic                     out_cout,
`ifdef BK_SEQ_OVF_EN
    output logic                     out_ovf,
`endif
    output logic [WORD_W-1:0]        add_a,
    output logic [WORD_W-1:0]        add_b,
    output logic                     add_cin,
    input  logic [WORD_W-1:0]        add_sum,
    input  logic                     add_cout
);
    localparam int IDX_W = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_reg;
    logic [IDX_W-1:0]               idx_reg;
    logic                           carry_reg;
    logic                           in_ready_reg;
    logic                           out_valid_reg;
    logic [NWORDS-1:0][WORD_W-1:0]  a_reg;
    logic [NWORDS-1:0][WORD_W-1:0]  b_reg;
    logic [NWORDS-1:0][WORD_W-1:0]  sum_reg;
    logic                           last_word;
    logic                           running;

    assign running   = (state_reg == RUN);
    assign last_word = (idx_reg == IDX_W'(NWORDS - 1));

    // The adder bus is held at zero outside RUN so the attached adder never sees stale operands.
    assign add_a   = running ? a_reg[idx_reg] : '0;
    assign add_b   = running ? b_reg[idx_reg] : '0;
    assign add_cin = running & carry_reg;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_cout  = carry_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_sum_out
            assign out_sum[gi*WORD_W +: WORD_W] = sum_reg[gi];
        end
    endgenerate

`ifdef BK_SEQ_OVF_EN
    logic ovf_reg;
    logic a_msb;
    logic b_msb;

    assign a_msb   = a_reg[NWORDS-1][WORD_W-1];
    assign b_msb   = b_reg[NWORDS-1][WORD_W-1];
    assign out_ovf = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (running && last_word) begin
            ovf_reg <= (a_msb == b_msb) && (add_sum[WORD_W-1] != a_msb);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= in_a;
                        b_reg        <= in_b;
                        carry_reg    <= in_cin;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg] <= add_sum;
                    carry_reg        <= add_cout;
                    if (last_word) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready only returns after the handoff edge; no same-cycle bypass.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
